// File: rtl/au_prefix_logic_pipe.sv
// au_prefix_logic_pipe: pipelined prefix AND/OR/XOR (serial, Brent-Kung or Sklansky tree)
// with valid/ready handshake and PIPE register stages spread evenly over the tree levels.
module au_prefix_logic_pipe #(
    parameter int WIDTH = 8,
    parameter int ARCH  = 2,
    parameter int PIPE  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] pi,
    input  logic [1:0]       mode,
    input  logic             rev,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] po,
    output logic [1:0]       mode_o,
    output logic             rev_o
);
    localparam int M = WIDTH > 1 ? $clog2(WIDTH) : 1;
    localparam int D = ARCH == 0 ? (WIDTH > 2 ? WIDTH - 1 : 1) : ARCH == 1 ? 2 * M - 1 : M;

    function automatic logic op(input logic a, input logic b, input logic [1:0] m);
        return m == 2'd1 ? a | b : m == 2'd2 ? a ^ b : a & b;
    endfunction

    function automatic logic [WIDTH-1:0] brev(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] y;
        for (int i = 0; i < WIDTH; i++) y[i] = x[WIDTH-1-i];
        return y;
    endfunction

    // One tree level: j is the partner bit feeding black node i, -1 for a white node.
    function automatic logic [WIDTH-1:0] lvl(input logic [WIDTH-1:0] x, input int l, input logic [1:0] m);
        logic [WIDTH-1:0] y;
        int j, s;
        y = x;
        for (int i = 0; i < WIDTH; i++) begin
            s = 1 << (l <= M ? l : 2 * M - l);
            if (ARCH == 0) j = i == l ? i - 1 : -1;
            else if (ARCH == 2) j = ((i >> (l - 1)) & 1) != 0 ? ((i >> (l - 1)) << (l - 1)) - 1 : -1;
            else j = (i + 1) % s == (l <= M ? 0 : s / 2) ? i - s / 2 : -1;
            if (j >= 0) y[i] = op(x[j], x[i], m);
        end
        return y;
    endfunction

    function automatic logic [WIDTH-1:0] run(input logic [WIDTH-1:0] x, input logic [1:0] m, input int lo, input int hi);
        logic [WIDTH-1:0] y;
        y = x;
        for (int l = 1; l <= D; l++) if (l > lo && l <= hi) y = lvl(y, l, m);
        return y;
    endfunction

    logic [WIDTH-1:0] data_q [PIPE+1];
    logic [WIDTH-1:0] data_d [PIPE+1];
    logic [WIDTH-1:0] st_x   [PIPE+1];
    logic [1:0]       mode_q [PIPE+1];
    logic [1:0]       mode_d [PIPE+1];
    logic [1:0]       st_m   [PIPE+1];
    logic             rev_q  [PIPE+1];
    logic             rev_d  [PIPE+1];
    logic             st_r   [PIPE+1];
    logic             vld_q  [PIPE+1];
    logic             vld_d  [PIPE+1];
    logic             st_v   [PIPE+1];
    logic [WIDTH-1:0] t;
    logic             en;

    // Stage s evaluates tree levels (s*D/(PIPE+1), (s+1)*D/(PIPE+1)]; the last stage is the output register.
    always_comb begin
        en = !vld_q[PIPE] || out_ready;
        st_x[0] = rev ? brev(pi) : pi;
        st_m[0] = mode;
        st_r[0] = rev;
        st_v[0] = in_valid;
        for (int s = 1; s <= PIPE; s++) begin
            st_x[s] = data_q[s-1];
            st_m[s] = mode_q[s-1];
            st_r[s] = rev_q[s-1];
            st_v[s] = vld_q[s-1];
        end
        for (int s = 0; s <= PIPE; s++) begin
            t = run(st_x[s], st_m[s], s * D / (PIPE + 1), (s + 1) * D / (PIPE + 1));
            data_d[s] = en ? (s == PIPE && st_r[s] ? brev(t) : t) : data_q[s];
            mode_d[s] = en ? st_m[s] : mode_q[s];
            rev_d[s]  = en ? st_r[s] : rev_q[s];
            vld_d[s]  = en ? st_v[s] : vld_q[s];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '{default: '0};
            mode_q <= '{default: '0};
            rev_q  <= '{default: '0};
            vld_q  <= '{default: '0};
        end else begin
            data_q <= data_d;
            mode_q <= mode_d;
            rev_q  <= rev_d;
            vld_q  <= vld_d;
        end
    end

    assign in_ready  = en;
    assign out_valid = vld_q[PIPE];
    assign po        = data_q[PIPE];
    assign mode_o    = mode_q[PIPE];
    assign rev_o     = rev_q[PIPE];
endmodule

// File: tb/tb_au_prefix_logic_pipe.sv
// tb_au_prefix_logic_pipe: directed checks on an 8-bit Sklansky PIPE=2 instance plus a
// randomized sweep of several WIDTH/ARCH/PIPE instances against a plain prefix model.
module tb_au_prefix_logic_pipe;
    logic clk = 0;
    always #5 clk = ~clk;

    int tests = 0, fails = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // po[i] = op over pi[0..i] (rev=0) or pi[i..w-1] (rev=1); mode 3 behaves as AND.
    function automatic logic [31:0] ref_po(input logic [31:0] x, input int w, input logic [1:0] m, input logic r);
        logic [31:0] y;
        logic a;
        int lo, hi;
        y = '0;
        for (int i = 0; i < w; i++) begin
            lo = r ? i : 0;
            hi = r ? w - 1 : i;
            a = x[lo];
            for (int k = lo + 1; k <= hi; k++) a = m == 2'd1 ? a | x[k] : m == 2'd2 ? a ^ x[k] : a & x[k];
            y[i] = a;
        end
        return y;
    endfunction

    logic       rst, in_valid, in_ready, rev, out_valid, out_ready, rev_o;
    logic [7:0] pi, po;
    logic [1:0] mode, mode_o;

    au_prefix_logic_pipe #(.WIDTH(8), .ARCH(2), .PIPE(2)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .pi(pi), .mode(mode),
        .rev(rev), .out_valid(out_valid), .out_ready(out_ready), .po(po), .mode_o(mode_o), .rev_o(rev_o)
    );

    logic        sw_rst = 1, sw_vld = 0, sw_rdy = 1, sw_rev = 0, sw_done = 0;
    logic [31:0] sw_pi = '0;
    logic [1:0]  sw_mode = '0;

    localparam int NC = 10;
    localparam logic [NC*8-1:0] CW = {8'd32, 8'd8, 8'd5, 8'd13, 8'd32, 8'd32, 8'd13, 8'd8, 8'd5, 8'd1};
    localparam logic [NC*8-1:0] CA = {8'd0, 8'd1, 8'd0, 8'd2, 8'd2, 8'd1, 8'd0, 8'd2, 8'd1, 8'd0};
    localparam logic [NC*8-1:0] CP = {8'd3, 8'd8, 8'd3, 8'd1, 8'd8, 8'd0, 8'd8, 8'd3, 8'd1, 8'd0};

    for (genvar g = 0; g < NC; g++) begin : g_sw
        localparam int W = int'(CW[g*8 +: 8]);
        localparam int A = int'(CA[g*8 +: 8]);
        localparam int P = int'(CP[g*8 +: 8]);
        logic         irdy, ov, ro;
        logic [W-1:0] po_w;
        logic [1:0]   mo;
        logic [31:0]  q_po[$];
        logic [1:0]   q_m[$];
        logic         q_r[$];
        int           q_c[$], q_s[$];
        int           stalls = 0;
        bit           seen = 0, dn = 0;

        au_prefix_logic_pipe #(.WIDTH(W), .ARCH(A), .PIPE(P)) u_sw (
            .clk(clk), .rst(sw_rst), .in_valid(sw_vld), .in_ready(irdy), .pi(sw_pi[W-1:0]), .mode(sw_mode),
            .rev(sw_rev), .out_valid(ov), .out_ready(sw_rdy), .po(po_w), .mode_o(mo), .rev_o(ro)
        );

        always begin
            @(negedge clk);
            #2;
            if (sw_rst) begin
                q_po.delete(); q_m.delete(); q_r.delete(); q_c.delete(); q_s.delete();
                seen = 0;
            end else begin
                if (ov && !seen) begin
                    seen = 1;
                    if (q_po.size() == 0) chk($sformatf("sw%0d_spurious", g), ov, 0);
                    else if (q_s[0] == stalls) chk($sformatf("sw%0d_latency", g), cyc - q_c[0], P + 1);
                end
                if (ov && sw_rdy && q_po.size() > 0) begin
                    chk($sformatf("sw%0d_po", g), 32'(po_w), q_po[0]);
                    chk($sformatf("sw%0d_mode_o", g), mo, q_m[0]);
                    chk($sformatf("sw%0d_rev_o", g), ro, q_r[0]);
                    void'(q_po.pop_front()); void'(q_m.pop_front()); void'(q_r.pop_front());
                    void'(q_c.pop_front()); void'(q_s.pop_front());
                    seen = 0;
                end
                if (ov && !sw_rdy) stalls++;
                if (sw_vld && irdy) begin
                    q_po.push_back(ref_po(sw_pi, W, sw_mode, sw_rev));
                    q_m.push_back(sw_mode);
                    q_r.push_back(sw_rev);
                    q_c.push_back(cyc);
                    q_s.push_back(stalls);
                end
            end
            if (sw_done && !dn) begin
                dn = 1;
                chk($sformatf("sw%0d_leftover", g), q_po.size(), 0);
            end
        end
    end

    task automatic send1(input string tag, input logic [7:0] p, input logic [1:0] m, input logic r, input logic [7:0] ep);
        int n;
        @(negedge clk);
        pi = p; mode = m; rev = r; in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        n = 1;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, n, 3);
        chk({tag, "_po"}, po, ep);
        chk({tag, "_mode_o"}, mode_o, m);
        chk({tag, "_rev_o"}, rev_o, r);
    endtask

    logic [7:0] bp_pi[6], hold_po;
    logic [1:0] bp_m[6], hold_m;
    logic       bp_r[6], prev_st;
    int         sent, got, stalled, n;

    initial begin
        rst = 1; in_valid = 1; pi = 8'hFF; mode = 0; rev = 0; out_ready = 1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_po", po, 0);
        end
        rst = 0; in_valid = 0;
        @(negedge clk);
        chk("idle_in_ready", in_ready, 1);
        chk("idle_out_valid", out_valid, 0);

        send1("lat_and", 8'b1110_1111, 2'd0, 1'b0, 8'b0000_1111);
        send1("lat_or", 8'b0001_0000, 2'd1, 1'b0, 8'b1111_0000);

        @(negedge clk);
        pi = 8'b0000_0101; mode = 2; rev = 0; in_valid = 1;
        @(negedge clk);
        pi = 8'b1000_0000; mode = 0; rev = 1;
        @(negedge clk);
        in_valid = 0;
        n = 2;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_latency", n, 3);
        chk("b2b_xor_po", po, 8'b0000_0011);
        chk("b2b_xor_mode_o", mode_o, 2);
        chk("b2b_xor_rev_o", rev_o, 0);
        @(negedge clk);
        chk("b2b_consecutive", out_valid, 1);
        chk("b2b_rev_po", po, 8'b1000_0000);
        chk("b2b_rev_mode_o", mode_o, 0);
        chk("b2b_rev_rev_o", rev_o, 1);

        for (int i = 0; i < 6; i++) begin
            bp_pi[i] = 8'($urandom);
            bp_m[i] = 2'($urandom);
            bp_r[i] = 1'($urandom);
        end
        sent = 0; got = 0; stalled = 0; prev_st = 0; hold_po = 0; hold_m = 0;
        for (int c = 0; c < 60 && got < 6; c++) begin
            @(negedge clk);
            out_ready = !(out_valid && stalled < 4);
            if (!out_ready) stalled++;
            in_valid = sent < 6;
            pi = bp_pi[sent < 6 ? sent : 0];
            mode = bp_m[sent < 6 ? sent : 0];
            rev = bp_r[sent < 6 ? sent : 0];
            #1;
            if (!out_ready) begin
                chk("bp_in_ready_stall", in_ready, 0);
                if (prev_st) begin
                    chk("bp_po_stable", po, hold_po);
                    chk("bp_mode_o_stable", mode_o, hold_m);
                end
                hold_po = po;
                hold_m = mode_o;
            end
            prev_st = !out_ready;
            if (out_valid && out_ready) begin
                chk("bp_po", po, ref_po(32'(bp_pi[got]), 8, bp_m[got], bp_r[got]));
                chk("bp_mode_o", mode_o, bp_m[got]);
                chk("bp_rev_o", rev_o, bp_r[got]);
                got++;
            end
            if (in_valid && in_ready) sent++;
        end
        chk("bp_stall_cycles", stalled, 4);
        chk("bp_received", got, 6);
        chk("bp_sent", sent, 6);
        in_valid = 0; out_ready = 1;
        repeat (4) begin
            @(negedge clk);
            chk("bp_no_duplicate", out_valid, 0);
        end

        @(negedge clk);
        out_ready = 0; in_valid = 1; pi = 8'h11; mode = 1; rev = 0;
        @(negedge clk);
        pi = 8'h22;
        @(negedge clk);
        pi = 8'h33;
        @(negedge clk);
        in_valid = 0; rst = 1;
        @(negedge clk);
        rst = 0; out_ready = 1;
        for (int i = 0; i < 5; i++) begin
            chk("rmf_flushed", out_valid, 0);
            @(negedge clk);
        end
        send1("rmf_after", 8'b1111_0111, 2'd0, 1'b1, 8'b1111_0000);

        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            sw_rst = 0;
            sw_vld = $urandom_range(0, 3) != 0;
            sw_rdy = $urandom_range(0, 3) != 0;
            sw_pi = $urandom;
            sw_mode = 2'($urandom);
            sw_rev = 1'($urandom);
        end
        @(negedge clk);
        sw_vld = 0; sw_rdy = 1;
        repeat (20) @(negedge clk);
        sw_done = 1;
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
